cs_y_collector: RTL

- Downstream stage of the CS filter: samples the 10-bit Y stream every clock once CS warm-up is over and buffers it in a small FIFO.
- Presents the samples to a consumer over a valid/ready handshake.
- Tracks overflow (sticky flag plus drop counter) and the running maximum of Y.
- Isolates the free-running CS output from a consumer that may stall.

---
 rtl/cs_y_collector_if.sv | 13 +
 rtl/cs_y_collector.sv | 106 ++++++++++
 2 files changed

// File: rtl/cs_y_collector_if.sv
// Consumer-facing sample stream of the CS Y collector: head sample,
// non-empty flag and the consumer's accept strobe.
interface cs_y_collector_if;
   logic [9:0] out_data;
   logic       out_valid;
   logic       out_ready;

   // The collector drives data/valid and listens to ready
   modport master (output out_data, output out_valid, input out_ready);

   // The consumer listens to data/valid and drives ready
   modport slave (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/cs_y_collector.sv
// Downstream stage of the CS filter. Once the CS window has filled, it
// takes one Y sample per clock into a small first-word-fall-through FIFO.
// The FIFO decouples the free-running filter from a consumer that may stall.
// The block also keeps overflow statistics and the running maximum of Y.
module cs_y_collector #(
   parameter int WARMUP = 9,
   parameter int DEPTH  = 8,
   parameter int AW     = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [9:0]          Y,
   input  logic                clr,
   cs_y_collector_if.master    stream,
   output logic [AW:0]         count,
   output logic                full,
   output logic                ovf,
   output logic [7:0]          drop_cnt,
   output logic [9:0]          y_max
);

   localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam logic [WW-1:0] WARM_LAST  = WW'(WARMUP);
   localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);

   logic [WW-1:0] warm_cnt;
   logic          sample_en;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [9:0]    mem [DEPTH];
   logic          pop;
   logic          drop;
   logic          push;

   // A sample is only lost when the FIFO is full and nothing leaves on the
   // same edge. A simultaneous pop frees a slot, so a push into a full FIFO
   // still succeeds on that edge.
   assign sample_en        = (warm_cnt == WARM_LAST);
   assign pop              = stream.out_valid & stream.out_ready;
   assign drop             = sample_en & full & ~pop;
   assign push             = sample_en & ~drop;
   assign full             = (count == COUNT_FULL);
   assign stream.out_valid = (count != '0);
   assign stream.out_data  = mem[rd_ptr];

   // Count edges after reset release until the CS window is full, then hold
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         warm_cnt <= '0;
      end else if (!sample_en) begin
         warm_cnt <= warm_cnt + 1'b1;
      end
   end

   // Storage array; contents are meaningless until written, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= Y;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // clr wins over a same-edge update, so its Y never reaches the stats
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf      <= 1'b0;
         drop_cnt <= '0;
         y_max    <= '0;
      end else if (clr) begin
         ovf      <= 1'b0;
         drop_cnt <= '0;
         y_max    <= '0;
      end else if (sample_en) begin
         if (Y > y_max) begin
            y_max <= Y;
         end
         if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != 8'hFF) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end
      end
   end

endmodule
